// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: sequencer state encoding
// and default sizing of the byte queue and busy-handshake timeout.
package uart_pkg;

    localparam int DEPTH_DEF        = 16;
    localparam int ADDR_W_DEF       = 4;
    localparam int BUSY_TIMEOUT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Byte queue with registered wrapping pointers and a separate occupancy count.
// A push into a full queue is accepted only when a pop frees a slot the same cycle.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            wr_en_i,
    input  logic [7:0]      wr_data_i,
    input  logic            rd_en_i,
    output logic [7:0]      rd_data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [ADDR_W:0] count_o,
    output logic            overflow_o
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push, pop;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign rd_data_o  = mem_q[rd_ptr_q];

    assign pop  = rd_en_i && !empty_o;
    assign push = wr_en_i && (!full_o || pop) && !flush_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            // A dropped byte is one offered while full with no slot freed this cycle.
            if (wr_en_i && full_o && !pop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues host bytes and hands them to uart_transmitter one at a time: pop, strobe
// Tx_WR, then wait for Tx_BUSY to rise and fall (or time out) before the next byte.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [7:0]      wr_data,
    input  logic            flush,
    output logic            full,
    output logic            empty,
    output logic [ADDR_W:0] count,
    output logic            overflow,
    output logic [7:0]      Tx_DATA,
    output logic            Tx_WR,
    input  logic            Tx_BUSY,
    output logic            timeout_err
);

    localparam int               TMO_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

    tx_state_e        state_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [7:0]       tx_data_q;
    logic             tx_wr_q;
    logic             timeout_err_q;
    logic [7:0]       fifo_rd_data;
    logic             pop;

    // A flushed queue must not leak its head byte, so flush also blocks the pop.
    assign pop = (state_q == IDLE) && !empty && !Tx_BUSY && !flush;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i      (clk),
        .rst_i      (reset),
        .flush_i    (flush),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .rd_en_i    (pop),
        .rd_data_o  (fifo_rd_data),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count),
        .overflow_o (overflow)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            tmo_cnt_q     <= '0;
            tx_data_q     <= 8'h00;
            tx_wr_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            tx_wr_q <= 1'b0;
            if (flush) timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        tx_data_q <= fifo_rd_data;
                        tx_wr_q   <= 1'b1;
                        state_q   <= STROBE;
                    end
                end
                STROBE: begin
                    tmo_cnt_q <= '0;
                    state_q   <= WAIT_HI;
                end
                WAIT_HI: begin
                    // A byte the transmitter never acknowledges is dropped, not retried.
                    if (Tx_BUSY) begin
                        state_q <= WAIT_LO;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        if (!flush) timeout_err_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!Tx_BUSY) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Tx_DATA     = tx_data_q;
    assign Tx_WR       = tx_wr_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a queue-level reference model checked every
// cycle, a simple transmitter responder, and literal expectations per scenario.
module tb_uart_tx_feeder;

    localparam int DEPTH        = 16;
    localparam int ADDR_W       = 4;
    localparam int BUSY_TIMEOUT = 8;

    logic            clk;
    logic            reset = 1'b1;
    logic            wr_en = 1'b0;
    logic [7:0]      wr_data = 8'h00;
    logic            flush = 1'b0;
    logic            full, empty, overflow, Tx_WR, timeout_err;
    logic [ADDR_W:0] count;
    logic [7:0]      Tx_DATA;
    logic            Tx_BUSY = 1'b0;

    int errors = 0;
    int checks = 0;

    // Transmitter responder: 0 = busy one cycle after Tx_WR for busy_len cycles,
    // 1 = busy tied low, 2 = busy forced high.
    int xmit_mode = 0;
    int busy_len  = 20;
    int busy_cnt  = 0;
    bit arm       = 1'b0;

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_strobe, m_rise, m_fall;
    int         m_waited;
    bit         m_ovf, m_tmo, m_wr;
    logic [7:0] m_data;
    bit         p_idle, p_pop, p_push, p_drop;

    logic [7:0] tx_log[$];
    logic [7:0] exp_log[$];

    uart_tx_feeder #(
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .flush       (flush),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .Tx_DATA     (Tx_DATA),
        .Tx_WR       (Tx_WR),
        .Tx_BUSY     (Tx_BUSY),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_log(input string name);
        chk({name, "_len"}, 32'(tx_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < tx_log.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), 32'(tx_log[i]), 32'(exp_log[i]));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (!(empty && !Tx_BUSY && !(m_strobe || m_rise || m_fall)) && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
        end
        repeat (3) tick();
    endtask

    // Transmitter responder
    initial forever begin
        @(posedge clk);
        #1;
        if (reset) begin
            busy_cnt = 0;
            arm      = 1'b0;
            Tx_BUSY  = 1'b0;
        end else begin
            case (xmit_mode)
                1: begin Tx_BUSY = 1'b0; busy_cnt = 0; arm = 1'b0; end
                2: begin Tx_BUSY = 1'b1; busy_cnt = 0; arm = 1'b0; end
                default: begin
                    if (busy_cnt > 0) begin
                        busy_cnt--;
                        if (busy_cnt == 0) Tx_BUSY = 1'b0;
                    end else if (arm) begin
                        Tx_BUSY  = 1'b1;
                        busy_cnt = busy_len;
                        arm      = 1'b0;
                    end else begin
                        Tx_BUSY = 1'b0;
                    end
                    if (Tx_WR) arm = 1'b1;
                end
            endcase
        end
    end

    // Reference model: byte queue plus "one byte in flight" bookkeeping
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_q.delete();
            m_strobe = 0; m_rise = 0; m_fall = 0; m_waited = 0;
            m_ovf = 0; m_tmo = 0; m_wr = 0; m_data = 8'h00;
        end else begin
            p_idle = !(m_strobe || m_rise || m_fall);
            p_pop  = p_idle && (m_q.size() > 0) && !Tx_BUSY && !flush;
            p_push = wr_en && !flush && ((m_q.size() < DEPTH) || p_pop);
            p_drop = wr_en && !flush && (m_q.size() == DEPTH) && !p_pop;

            if (m_strobe) begin
                m_strobe = 0;
                m_rise   = 1;
                m_waited = 0;
            end else if (m_rise) begin
                if (Tx_BUSY) begin
                    m_rise = 0;
                    m_fall = 1;
                end else begin
                    m_waited++;
                    if (m_waited == BUSY_TIMEOUT) begin
                        m_rise = 0;
                        if (!flush) m_tmo = 1;
                    end
                end
            end else if (m_fall) begin
                if (!Tx_BUSY) m_fall = 0;
            end

            m_wr = p_pop;
            if (p_pop) begin
                m_data   = m_q.pop_front();
                m_strobe = 1;
            end
            if (flush) begin
                m_q.delete();
                m_ovf = 0;
                m_tmo = 0;
            end else if (p_drop) begin
                m_ovf = 1;
            end
            if (p_push) m_q.push_back(wr_data);
        end
    end

    // Per-cycle comparison against the model, plus a log of strobed bytes
    initial forever begin
        @(negedge clk);
        chk("count",       32'(count),       32'(m_q.size()));
        chk("empty",       32'(empty),       32'(m_q.size() == 0));
        chk("full",        32'(full),        32'(m_q.size() == DEPTH));
        chk("overflow",    32'(overflow),    32'(m_ovf));
        chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
        chk("Tx_WR",       32'(Tx_WR),       32'(m_wr));
        chk("Tx_DATA",     32'(Tx_DATA),     32'(m_data));
        if (Tx_WR) begin
            tx_log.push_back(Tx_DATA);
            chk("wr_while_busy", 32'(Tx_BUSY), 32'(0));
        end
    end

    initial begin
        repeat (3) tick();
        chk("rst_empty",    32'(empty),       32'(1));
        chk("rst_full",     32'(full),        32'(0));
        chk("rst_count",    32'(count),       32'(0));
        chk("rst_overflow", 32'(overflow),    32'(0));
        chk("rst_timeout",  32'(timeout_err), 32'(0));
        chk("rst_Tx_WR",    32'(Tx_WR),       32'(0));
        chk("rst_Tx_DATA",  32'(Tx_DATA),     32'(8'h00));
        reset = 1'b0;
        tick();

        // Single byte: strobe two cycles after the push cycle
        tx_log.delete();
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        chk("t1_wr_early", 32'(Tx_WR), 32'(0));
        chk("t1_count1",   32'(count), 32'(1));
        tick();
        chk("t1_wr_pulse", 32'(Tx_WR),   32'(1));
        chk("t1_data",     32'(Tx_DATA), 32'(8'hA5));
        chk("t1_empty0",   32'(empty),   32'(1));
        tick();
        chk("t1_wr_single", 32'(Tx_WR), 32'(0));
        drain("t1");
        chk("t1_empty", 32'(empty), 32'(1));
        exp_log = '{8'hA5};
        chk_log("t1_log");

        // Burst ordering: fill while the transmitter is externally busy
        tx_log.delete();
        xmit_mode = 2;
        tick();
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("t2_full",  32'(full),     32'(1));
        chk("t2_count", 32'(count),    32'(16));
        chk("t2_ovf",   32'(overflow), 32'(0));
        xmit_mode = 0;
        drain("t2");
        exp_log.delete();
        for (int i = 1; i <= 16; i++) exp_log.push_back(8'(i));
        chk_log("t2_log");
        chk("t2_ovf_end", 32'(overflow), 32'(0));

        // Overflow: push while full and blocked
        tx_log.delete();
        xmit_mode = 2;
        tick();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'h20 + 8'(i);
            tick();
        end
        wr_en = 1'b1; wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        chk("t3_ovf",   32'(overflow), 32'(1));
        chk("t3_count", 32'(count),    32'(16));
        xmit_mode = 0;
        drain("t3");
        exp_log.delete();
        for (int i = 0; i < 16; i++) exp_log.push_back(8'h20 + 8'(i));
        chk_log("t3_log");
        chk("t3_ovf_sticky", 32'(overflow), 32'(1));

        // Full queue, push on the pop edge
        tx_log.delete();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_ovf_cleared", 32'(overflow), 32'(0));
        xmit_mode = 2;
        tick();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("t4_full", 32'(count), 32'(16));
        xmit_mode = 0;
        tick();
        wr_en = 1'b1; wr_data = 8'h77;
        tick();
        wr_en = 1'b0;
        chk("t4_pop",   32'(Tx_WR),    32'(1));
        chk("t4_count", 32'(count),    32'(16));
        chk("t4_ovf",   32'(overflow), 32'(0));
        drain("t4");
        exp_log.delete();
        for (int i = 0; i < 16; i++) exp_log.push_back(8'h40 + 8'(i));
        exp_log.push_back(8'h77);
        chk_log("t4_log");

        // Timeout: transmitter never acknowledges
        tx_log.delete();
        xmit_mode = 1;
        tick();
        wr_en = 1'b1; wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        tick();
        chk("t5_wr", 32'(Tx_WR), 32'(1));
        repeat (8) tick();
        chk("t5_tmo_not_yet", 32'(timeout_err), 32'(0));
        tick();
        chk("t5_tmo_set", 32'(timeout_err), 32'(1));
        xmit_mode = 0;
        wr_en = 1'b1; wr_data = 8'h3D;
        tick();
        wr_en = 1'b0;
        drain("t5");
        exp_log = '{8'h3C, 8'h3D};
        chk_log("t5_log");
        chk("t5_tmo_sticky", 32'(timeout_err), 32'(1));

        // Flush with a byte in flight and a simultaneous push
        tx_log.delete();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_tmo_cleared", 32'(timeout_err), 32'(0));
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'h50 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("t6_queued", 32'(count), 32'(3));
        tick();
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        chk("t6_count", 32'(count), 32'(0));
        chk("t6_empty", 32'(empty), 32'(1));
        drain("t6");
        exp_log = '{8'h50};
        chk_log("t6_log");

        // Reset mid-transfer with five bytes queued
        tx_log.delete();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("t7_queued", 32'(count), 32'(5));
        repeat (2) tick();
        reset = 1'b1;
        #1;
        chk("t7_Tx_WR",   32'(Tx_WR),   32'(0));
        chk("t7_count",   32'(count),   32'(0));
        chk("t7_empty",   32'(empty),   32'(1));
        chk("t7_Tx_DATA", 32'(Tx_DATA), 32'(8'h00));
        tick();
        reset = 1'b0;
        tick();
        tx_log.delete();
        wr_en = 1'b1; wr_data = 8'h70;
        tick();
        wr_en = 1'b0;
        drain("t7");
        exp_log = '{8'h70};
        chk_log("t7_log");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte FIFO and write sequencer sitting directly upstream of uart_transmitter, in the clk1 domain.
- Host logic pushes bytes at any rate; the block pops one byte at a time, presents it on Tx_DATA, pulses Tx_WR, and waits for the transmitter to finish (Tx_BUSY high then low) before issuing the next byte.
- Decouples bursty producers from the serial baud rate.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH).
- BUSY_TIMEOUT, 8, cycles to wait for Tx_BUSY to rise after a Tx_WR pulse before giving up on that byte.

Ports:
- clk  input  1  system clock (clk1 domain).
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  push wr_data into the FIFO this cycle.
- wr_data  input  8  byte to enqueue.
- flush  input  1  synchronous clear of FIFO contents.
- full  output  1  FIFO holds DEPTH bytes.
- empty  output  1  FIFO holds 0 bytes.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when wr_en is asserted while full and no pop occurs that cycle.
- Tx_DATA  output  8  byte to uart_transmitter; held stable from the Tx_WR pulse until the FSM returns to IDLE.
- Tx_WR  output  1  single-cycle write strobe to uart_transmitter.
- Tx_BUSY  input  1  transmitter busy flag.
- timeout_err  output  1  sticky; set when a BUSY_TIMEOUT expiry occurs.

Behaviour:
- Reset (async, active-high):
  - Pointers and count go to 0; empty=1, full=0.
  - overflow=0, timeout_err=0, Tx_WR=0, Tx_DATA=8'h00; FSM in IDLE.
- FIFO: registered read and write pointers, ADDR_W bits each, wrapping modulo DEPTH. count is a separate register.
  - Push accepted when wr_en && (!full || pop this cycle).
  - Simultaneous push and pop: count unchanged; legal when full (pop frees the slot the same cycle) and when empty is impossible because pop requires !empty.
  - Push while full with no pop: data dropped, overflow set.
- Pop rule: pop occurs only in IDLE when !empty and Tx_BUSY==0. The popped byte is registered into Tx_DATA on the same edge, and Tx_WR is asserted for the next cycle.
- FSM states:
  - IDLE: if !empty && !Tx_BUSY, pop and go to STROBE; otherwise stay.
  - STROBE: Tx_WR=1 for exactly one cycle; clear timeout counter; go to WAIT_HI.
  - WAIT_HI: if Tx_BUSY, go to WAIT_LO. Otherwise increment the counter; when the counter reaches BUSY_TIMEOUT-1, set timeout_err and go to IDLE. The byte is considered consumed and is not retried.
  - WAIT_LO: when Tx_BUSY==0, go to IDLE.
- Throughput: minimum 3 cycles between Tx_WR pulses plus the transmitter busy time. First Tx_WR occurs 2 cycles after the push edge into an empty FIFO (push edge → IDLE sees !empty → pop edge → STROBE).
- flush:
  - Clears pointers and count on the next edge; overrides a simultaneous push.
  - Does not abort an in-flight byte; the FSM completes its WAIT states normally.
  - Clears overflow and timeout_err.
- Tx_BUSY already high in IDLE (external activity): no pop until it falls.
- Reset mid-transfer: FSM returns to IDLE immediately. Tx_WR drops asynchronously. The FIFO is emptied.
- Widths: count is ADDR_W+1 bits so that DEPTH is representable. full = (count==DEPTH); empty = (count==0).

Decomposition:
- Shared package (uart_pkg): FSM state encoding constants (IDLE, STROBE, WAIT_HI, WAIT_LO) and the default DEPTH/ADDR_W/BUSY_TIMEOUT values.
- One natural sub-module, sync_fifo: parameterised DEPTH/ADDR_W storage, pointers, count, full, empty and overflow.
- The sequencer FSM stays in uart_tx_feeder.

Test Plan:
- Single byte: push 8'hA5 into an empty FIFO, with a transmitter model raising Tx_BUSY 1 cycle after Tx_WR and holding it 20 cycles → exactly one Tx_WR pulse 2 cycles after the push, Tx_DATA=8'hA5, empty=1 afterwards, no further Tx_WR.
- Burst ordering: push 8'h01..8'h10 (16 bytes) back-to-back → full=1 after the 16th push, count=16; Tx_WR pulses emit the bytes 01..10 in order, never while Tx_BUSY=1; overflow stays 0.
- Overflow: fill to 16, hold Tx_BUSY=1 externally, push 8'hFF → overflow=1, count stays 16, 8'hFF never appears on Tx_DATA.
- Full push+pop same cycle: FIFO full, push 8'h77 on the pop edge → count stays 16, overflow=0, 8'h77 emitted last.
- Timeout: push 8'h3C, Tx_BUSY tied 0 → one Tx_WR, timeout_err=1 after 8 cycles in WAIT_HI, FSM back to IDLE; next pushed byte is still sent.
- Reset/flush mid-operation: assert reset during WAIT_LO with 5 bytes queued → Tx_WR=0, count=0, empty=1 immediately; separately, flush with 3 queued and a simultaneous push → count=0 next cycle, in-flight byte completes.
